// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and parity-mode constants shared by the UART RX files
// (UART_RX_PARITY_EN adds the PARITY state)
package uart_pkg;
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif
endpackage

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: synchronizes the serial line and deserializes one frame at a time.
// Emits one-cycle valid / frame_err / parity_err events the cycle after the stop-bit sample.
// Parity bit handling exists only when UART_RX_PARITY_EN is defined.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = PAR_EVEN
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx_serial_data,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    rx_state_t            state, nxt;
    logic [1:0]           sync;
    logic                 prev, line, fall, tick, half, last_bit, hold, par_bad, smp_stop;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;

    if (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) begin : g_bad_parity
        $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
    end

    assign line     = sync[1];
    assign fall     = prev && !line;
    assign tick     = cnt == CW'(CLKS_PER_BIT - 1);
    assign half     = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign last_bit = idx == 4'(DATA_BITS - 1);
    assign data     = shreg;

    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            prev <= 1'b1;
        end else begin
            sync <= {sync[0], rx_serial_data};
            prev <= line;
        end
    end

    // state register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next state: dropping rx_en aborts any frame; a frame error lingers in STOP until the line is high
    always_comb begin
        nxt = state;
        if (!rx_en) nxt = IDLE;
        else begin
            case (state)
                IDLE:    nxt = fall ? START : IDLE;
                START:   nxt = half ? (line ? IDLE : DATA) : START;
                DATA:    nxt = (tick && last_bit) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
                PARITY:  nxt = tick ? STOP : PARITY;
`endif
                STOP:    nxt = (hold ? line : (tick && line)) ? IDLE : STOP;
                default: nxt = IDLE;
            endcase
        end
    end

    // stop-bit sample strobe, suppressed while waiting out a broken stop bit
    always_comb smp_stop = rx_en && state == STOP && !hold && tick;

    // bit timing, LSB-first shifting and the line-high wait after a framing error
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            hold  <= 1'b0;
        end else begin
            cnt  <= (state == IDLE || state != nxt || tick) ? '0 : cnt + CW'(1);
            idx  <= (state != DATA) ? '0 : idx + 4'(tick);
            hold <= (state == STOP) && (hold || (tick && !line));
            if (state == DATA && tick) shreg <= {line, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // parity mismatch captured at the parity-bit midpoint
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)                       par_bad <= 1'b0;
        else if (state == PARITY && tick) par_bad <= ^shreg ^ line ^ (PARITY_ODD == PAR_ODD);
    end

    // frame outcome events, one cycle after the stop sample
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            valid      <= smp_stop && line && !par_bad;
            frame_err  <= smp_stop && !line;
            parity_err <= smp_stop && par_bad;
        end
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;

    // frame outcome events, one cycle after the stop sample
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= smp_stop && line && !par_bad;
            frame_err <= smp_stop && !line;
        end
    end
`endif
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receiver feeding a registered-read FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data bits.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int AE_THRESH    = 2,
    parameter int PARITY_ODD   = PAR_EVEN
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          rx_en,
    input  logic                          rx_serial_data,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          empty,
    output logic                          almost_empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fill_count,
    output logic                          overrun,
    output logic                          frame_err,
    output logic                          parity_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] word;
    logic [AW-1:0]        wp, rp;
    logic [FW-1:0]        nxt_fill;
    logic                 push, pop, wr, drop, ferr_ev, perr_ev;

    if (DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 4 || FIFO_DEPTH > 1024 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_buffered: illegal DATA_BITS or FIFO_DEPTH");
    end

    uart_rx_frame #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY_ODD   (PARITY_ODD)
    ) u_frame (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .rx_en          (rx_en),
        .rx_serial_data (rx_serial_data),
        .data           (word),
        .valid          (push),
        .frame_err      (ferr_ev),
        .parity_err     (perr_ev)
    );

    // a pop needs data; a push into a full FIFO only fits when a pop frees a slot in the same cycle
    assign pop      = rd_en && !empty;
    assign wr       = push && (!full || rd_en);
    assign drop     = push && full && !rd_en;
    assign nxt_fill = fill_count + FW'(wr) - FW'(pop);

    // storage array; contents behind the pointers are never observed, so no reset
    always_ff @(posedge clk_in) begin
        if (wr) mem[wp] <= word;
    end

    // pointers, registered read port and registered status
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wp           <= '0;
            rp           <= '0;
            dout         <= '0;
            fill_count   <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (pop) begin
                rp   <= rp + AW'(1);
                dout <= mem[rp];
            end
            fill_count   <= nxt_fill;
            empty        <= nxt_fill == '0;
            full         <= nxt_fill == FW'(FIFO_DEPTH);
            almost_empty <= nxt_fill <= FW'(AE_THRESH);
        end
    end

    // sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun    <= (overrun && !err_clr) || drop;
            frame_err  <= (frame_err && !err_clr) || ferr_ev;
            parity_err <= (parity_err && !err_clr) || perr_ev;
        end
    end
endmodule
